// File: rtl/ecc_dsa_uop_sequencer_if.sv
// ecc_dsa_uop_sequencer_if
//  Bundle between the ECC DSA uop sequencer and its surroundings: command
//  handshake, uop ROM port, issued-uop fields, datapath completion pulses and
//  status.
//  slave  : sequencer side (takes commands, drives ROM address and uops)
//  master : host/datapath side (issues commands, returns ROM data and dones)
interface ecc_dsa_uop_sequencer_if #(
  parameter int PROG_AW = 7,
  parameter int INSTR_W = 21
);
  logic               cmd_valid;
  logic [1:0]         cmd_sel;
  logic               cmd_ready;
  logic [PROG_AW-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_instr;
  logic               uop_valid;
  logic [8:0]         uop_opcode;
  logic [5:0]         uop_reg_id;
  logic [5:0]         uop_mem_addr;
  logic               pm_done;
  logic               drbg_done;
  logic               busy;
  logic               done;
  logic               error;

  modport slave (
    input  cmd_valid, cmd_sel, prog_instr, pm_done, drbg_done,
    output cmd_ready, prog_addr, uop_valid, uop_opcode, uop_reg_id,
           uop_mem_addr, busy, done, error
  );

  modport master (
    output cmd_valid, cmd_sel, prog_instr, pm_done, drbg_done,
    input  cmd_ready, prog_addr, uop_valid, uop_opcode, uop_reg_id,
           uop_mem_addr, busy, done, error
  );
endinterface

// File: rtl/ecc_dsa_uop_sequencer.sv
// ecc_dsa_uop_sequencer
//  Microcode program sequencer for the ECC DSA engine. A command selects one
//  of four subroutines in the uop ROM; the PC walks it one instruction at a
//  time, issuing decoded uops to the datapath, stalling on point-mult and
//  HMAC-DRBG completion, and pulsing done at the end.
//  Ports:
//   clk_i      clock
//   reset_n_i  async active-low reset
//   zeroize_i  sync clear, overrides everything
//   bus        sequencer side of ecc_dsa_uop_sequencer_if (cmd handshake,
//              ROM addr/data, uop fields, pm/drbg done, busy/done/error)
module ecc_dsa_uop_sequencer #(
  parameter int PROG_AW  = 7,
  parameter int INSTR_W  = 21,
  parameter int NOP_ADDR = 12,
  parameter int KG_S     = 14,
  parameter int KG_E     = 26,
  parameter int SGN_S    = 28,
  parameter int SGN_E    = 42,
  parameter int VER_S    = 44,
  parameter int VER_E    = 67,
  parameter int DH_S     = 69,
  parameter int DH_E     = 87,
  parameter int TIMEOUT  = 4095
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  zeroize_i,
  ecc_dsa_uop_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_PM   = 3'd3;
  localparam logic [2:0] ST_WAIT_DRBG = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  localparam logic [PROG_AW-1:0] NOP = PROG_AW'(NOP_ADDR);

  logic [2:0]         state_q, state_d;
  logic [PROG_AW-1:0] addr_q, addr_d;
  logic [PROG_AW-1:0] end_q, end_d;
  logic [8:0]         op_q, op_d;
  logic [5:0]         reg_q, reg_d;
  logic [5:0]         mem_q, mem_d;
  logic               uv_q, uv_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [11:0]        cnt_q, cnt_d;
  logic               pend_q, pend_d;   // DRBG wait still owed after PM wait

  logic [PROG_AW-1:0] start_sel, end_sel;
  logic [3:0]         pm_cmd;
  logic               drbg_en;
  logic               pm_legal;
  logic               advance;
  logic [11:0]        cnt_inc;

  assign pm_cmd  = bus.prog_instr[17:14];
  assign drbg_en = bus.prog_instr[13];
  assign cnt_inc = cnt_q + 12'd1;

  always_comb begin
    start_sel = PROG_AW'(KG_S);
    end_sel   = PROG_AW'(KG_E);
    case (bus.cmd_sel)
      2'd1:    begin start_sel = PROG_AW'(SGN_S); end_sel = PROG_AW'(SGN_E); end
      2'd2:    begin start_sel = PROG_AW'(VER_S); end_sel = PROG_AW'(VER_E); end
      2'd3:    begin start_sel = PROG_AW'(DH_S);  end_sel = PROG_AW'(DH_E);  end
      default: ;
    endcase
  end

  // Only these point-mult commands exist in the datapath.
  always_comb begin
    case (pm_cmd)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1000: pm_legal = 1'b1;
      default:                             pm_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    op_d    = op_q;
    reg_d   = reg_q;
    mem_d   = mem_q;
    uv_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = start_sel;
          end_d   = end_sel;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!pm_legal) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          uv_d  = 1'b1;
          op_d  = bus.prog_instr[20:12];
          reg_d = bus.prog_instr[11:6];
          mem_d = bus.prog_instr[5:0];
          if (pm_cmd != 4'd0) begin
            pend_d  = drbg_en;
            state_d = ST_WAIT_PM;
          end else if (drbg_en) begin
            state_d = ST_WAIT_DRBG;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_WAIT_PM, ST_WAIT_DRBG: begin
        if ((state_q == ST_WAIT_PM   && bus.pm_done) ||
            (state_q == ST_WAIT_DRBG && bus.drbg_done)) begin
          cnt_d = 12'd0;
          if (state_q == ST_WAIT_PM && pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_WAIT_DRBG;
          end else begin
            advance = 1'b1;
          end
        end else if (cnt_inc == 12'(TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = 12'd0;
          pend_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        addr_d  = NOP;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The end check runs before the increment, so the PC never passes end.
    if (advance) begin
      if (addr_q == end_q) begin
        state_d = ST_FINISH;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= NOP;
      end_q   <= NOP;
      op_q    <= '0;
      reg_q   <= '0;
      mem_q   <= '0;
      uv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else if (zeroize_i) begin
      state_q <= ST_IDLE;
      addr_q  <= NOP;
      end_q   <= NOP;
      op_q    <= '0;
      reg_q   <= '0;
      mem_q   <= '0;
      uv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      mem_q   <= mem_d;
      uv_q    <= uv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.prog_addr    = addr_q;
  assign bus.uop_valid    = uv_q;
  assign bus.uop_opcode   = op_q;
  assign bus.uop_reg_id   = reg_q;
  assign bus.uop_mem_addr = mem_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;

endmodule
